// File: rtl/fu_mul_pkg.sv
// fu_mul_pkg: mode encoding, default sizes and operand-extension control for fu_mul_pipe
package fu_mul_pkg;
  typedef enum logic [1:0] {
    MUL_LO  = 2'b00,
    MUL_HSS = 2'b01,
    MUL_HSU = 2'b10,
    MUL_HUU = 2'b11
  } mode_e;
  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 7;
  localparam int DEF_TAG_W  = 5;
  typedef struct packed {
    logic a_sgn;
    logic b_sgn;
  } ext_t;
  function automatic ext_t ext_ctl(input mode_e m);
    return '{a_sgn: m == MUL_HSS || m == MUL_HSU, b_sgn: m == MUL_HSS};
  endfunction
endpackage

// File: rtl/fu_mul_if.sv
// fu_mul_if: issue/result bundle between the execute stage and fu_mul_pipe
interface fu_mul_if import fu_mul_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TAG_W = DEF_TAG_W
);
  logic             EN, stall, flush, finish, busy;
  logic [1:0]       mode;
  logic [WIDTH-1:0] A, B, res;
  logic [TAG_W-1:0] tag_in, tag_out;
  modport master (output EN, stall, flush, mode, A, B, tag_in, input res, finish, tag_out, busy);
  modport slave (input EN, stall, flush, mode, A, B, tag_in, output res, finish, tag_out, busy);
endinterface

// File: rtl/fu_mul_slot.sv
// fu_mul_slot: one pipeline slot holding valid/mode/tag/data with stall hold and flush kill
module fu_mul_slot import fu_mul_pkg::*; #(
  parameter int DW    = 2 * DEF_WIDTH,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  mode_e            in_mode,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [DW-1:0]    in_data,
  output logic             valid_q,
  output mode_e            mode_q,
  output logic [TAG_W-1:0] tag_q,
  output logic [DW-1:0]    data_q
);
  logic             valid_d;
  mode_e            mode_d;
  logic [TAG_W-1:0] tag_d;
  logic [DW-1:0]    data_d;
  always_comb begin
    valid_d = flush ? 1'b0 : stall ? valid_q : in_valid;
    mode_d  = stall ? mode_q : in_mode;
    tag_d   = stall ? tag_q : in_tag;
    data_d  = stall ? data_q : in_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      mode_q  <= MUL_LO;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      mode_q  <= mode_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/fu_mul_pipe.sv
// fu_mul_pipe: pipelined RISC-V style multiplier with issue tag, stall and flush
module fu_mul_pipe import fu_mul_pkg::*; #(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES,
  parameter int TAG_W  = DEF_TAG_W
) (
  input logic     clk,
  input logic     rst,
  fu_mul_if.slave bus
);
  localparam int DW = 2 * WIDTH;
  logic [STAGES-1:0] v_in, v_q;
  mode_e             m_in [STAGES];
  mode_e             m_q  [STAGES];
  logic [TAG_W-1:0]  t_in [STAGES];
  logic [TAG_W-1:0]  t_q  [STAGES];
  logic [DW-1:0]     d_in [STAGES];
  logic [DW-1:0]     d_q  [STAGES];
  // Low 2*WIDTH bits of the extended product; enough for either result half.
  function automatic logic [DW-1:0] prod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                         input mode_e m);
    ext_t        e;
    logic [DW-1:0] ea, eb;
    e  = ext_ctl(m);
    ea = {{WIDTH{e.a_sgn & a[WIDTH-1]}}, a};
    eb = {{WIDTH{e.b_sgn & b[WIDTH-1]}}, b};
    return ea * eb;
  endfunction
  for (genvar i = 0; i < STAGES; i++) begin : g_slot
    if (i == 0) begin : g_head
      assign v_in[0] = bus.EN;
      assign m_in[0] = mode_e'(bus.mode);
      assign t_in[0] = bus.tag_in;
      // Slot 0 keeps raw operands so the multiply gets a full stage when STAGES > 1.
      assign d_in[0] = STAGES == 1 ? prod(bus.A, bus.B, mode_e'(bus.mode)) : {bus.A, bus.B};
    end else begin : g_body
      assign v_in[i] = v_q[i-1];
      assign m_in[i] = m_q[i-1];
      assign t_in[i] = t_q[i-1];
      assign d_in[i] = i == 1 ? prod(d_q[0][DW-1:WIDTH], d_q[0][WIDTH-1:0], m_q[0]) : d_q[i-1];
    end
    fu_mul_slot #(.DW(DW), .TAG_W(TAG_W)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .stall   (bus.stall),
      .flush   (bus.flush),
      .in_valid(v_in[i]),
      .in_mode (m_in[i]),
      .in_tag  (t_in[i]),
      .in_data (d_in[i]),
      .valid_q (v_q[i]),
      .mode_q  (m_q[i]),
      .tag_q   (t_q[i]),
      .data_q  (d_q[i])
    );
  end
  assign bus.finish  = v_q[STAGES-1];
  assign bus.tag_out = t_q[STAGES-1];
  assign bus.res     = m_q[STAGES-1] == MUL_LO ? d_q[STAGES-1][WIDTH-1:0] : d_q[STAGES-1][DW-1:WIDTH];
  assign bus.busy    = |v_q;
endmodule

// File: tb/tb_fu_mul_pipe.sv
// tb_fu_mul_pipe: directed bench with a latency-queue reference model for fu_mul_pipe
module tb_fu_mul_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fu_mul_if #(.WIDTH(32), .TAG_W(5)) m7 ();
  fu_mul_if #(.WIDTH(16), .TAG_W(5)) s1 ();
  fu_mul_if #(.WIDTH(16), .TAG_W(5)) s3 ();
  fu_mul_pipe #(.WIDTH(32), .STAGES(7), .TAG_W(5)) dut  (.clk(clk), .rst(rst), .bus(m7.slave));
  fu_mul_pipe #(.WIDTH(16), .STAGES(1), .TAG_W(5)) dut1 (.clk(clk), .rst(rst), .bus(s1.slave));
  fu_mul_pipe #(.WIDTH(16), .STAGES(3), .TAG_W(5)) dut3 (.clk(clk), .rst(rst), .bus(s3.slave));
  int tests = 0;
  int fails = 0;
  bit chk_on = 0;
  bit ev;
  typedef struct {
    logic [31:0] r;
    logic [4:0]  t;
    int          left;
  } op_t;
  op_t q[$];
  function automatic logic [31:0] mres(logic [1:0] m, logic [31:0] a, logic [31:0] b);
    logic signed [32:0] ea, eb;
    logic signed [65:0] p;
    ea = {(m == 2'd1 || m == 2'd2) && a[31], a};
    eb = {m == 2'd1 && b[31], b};
    p  = 66'(ea) * 66'(eb);
    return m == 2'd0 ? p[31:0] : p[63:32];
  endfunction
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Each in-flight op counts the unstalled edges left until it reaches the output.
  always @(posedge clk) begin
    if (rst || m7.flush) q.delete();
    else if (!m7.stall) begin
      if (q.size() != 0 && q[0].left == 0) void'(q.pop_front());
      foreach (q[k]) q[k].left--;
      if (m7.EN) q.push_back('{mres(m7.mode, m7.A, m7.B), m7.tag_in, 6});
    end
  end
  always @(negedge clk) if (chk_on) begin
    ev = q.size() != 0 && q[0].left == 0;
    check("cmp_finish", m7.finish, ev);
    check("cmp_busy", m7.busy, q.size() != 0);
    if (ev) begin
      check("cmp_res", m7.res, q[0].r);
      check("cmp_tag", m7.tag_out, q[0].t);
    end
  end
  task automatic run_op(string name, logic [1:0] m, logic [31:0] a, logic [31:0] b, logic [4:0] t,
                        logic [31:0] exp, int lat, int stall_at);
    int n;
    m7.EN = 1; m7.mode = m; m7.A = a; m7.B = b; m7.tag_in = t;
    @(negedge clk);
    m7.EN = 0;
    n = 1;
    while (!m7.finish && n < 30) begin
      m7.stall = stall_at >= 0 && n >= stall_at && n < stall_at + 3;
      @(negedge clk);
      n++;
    end
    m7.stall = 0;
    check({name, "_lat"}, n, lat);
    check({name, "_res"}, m7.res, exp);
    check({name, "_tag"}, m7.tag_out, t);
  endtask
  task automatic sweep(string name, logic [1:0] m, logic [15:0] exp);
    int l1 = -1, l3 = -1;
    logic [15:0] r1 = '0, r3 = '0;
    logic [4:0] t1 = '0, t3 = '0;
    s1.EN = 1; s1.mode = m; s1.A = 16'h8000; s1.B = 16'h8000; s1.tag_in = 5'd4;
    s3.EN = 1; s3.mode = m; s3.A = 16'h8000; s3.B = 16'h8000; s3.tag_in = 5'd4;
    @(negedge clk);
    s1.EN = 0; s3.EN = 0;
    for (int k = 1; k < 8; k++) begin
      if (s1.finish && l1 < 0) begin l1 = k; r1 = s1.res; t1 = s1.tag_out; end
      if (s3.finish && l3 < 0) begin l3 = k; r3 = s3.res; t3 = s3.tag_out; end
      @(negedge clk);
    end
    check({name, "_s1_lat"}, l1, 1);
    check({name, "_s1_res"}, r1, exp);
    check({name, "_s1_tag"}, t1, 5'd4);
    check({name, "_s3_lat"}, l3, 3);
    check({name, "_s3_res"}, r3, exp);
    check({name, "_s3_tag"}, t3, 5'd4);
  endtask
  initial begin
    int n;
    int fin_k[$];
    logic [4:0] fin_t[$];
    logic [31:0] fin_r[$];
    bit busy_k[40];
    m7.EN = 1; m7.stall = 0; m7.flush = 0; m7.mode = 0; m7.A = 5; m7.B = 5; m7.tag_in = 1;
    s1.EN = 1; s1.stall = 0; s1.flush = 0; s1.mode = 0; s1.A = 5; s1.B = 5; s1.tag_in = 1;
    s3.EN = 1; s3.stall = 0; s3.flush = 0; s3.mode = 0; s3.A = 5; s3.B = 5; s3.tag_in = 1;
    check("model_mul", mres(2'd0, 32'd7, 32'd6), 32'h0000002A);
    check("model_mulhu", mres(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFE);
    check("model_mulh", mres(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'h00000000);
    check("model_mulhsu", mres(2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_finish", m7.finish, 1'b0);
    check("rst_res", m7.res, 32'h0);
    check("rst_tag", m7.tag_out, 5'h0);
    check("rst_busy", m7.busy, 1'b0);
    check("rst_s1_finish", s1.finish, 1'b0);
    check("rst_s3_busy", s3.busy, 1'b0);
    rst = 0; m7.EN = 0; s1.EN = 0; s3.EN = 0;
    chk_on = 1;
    n = 0;
    repeat (9) begin
      @(negedge clk);
      n += int'(m7.finish);
    end
    check("rst_no_finish", n, 0);
    run_op("mul", 2'd0, 32'd7, 32'd6, 5'd3, 32'h0000002A, 7, -1);
    run_op("mulhu", 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11, 32'hFFFFFFFE, 7, -1);
    run_op("mulh", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 32'h00000000, 7, -1);
    run_op("mulhsu", 2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 32'hFFFFFFFF, 7, -1);
    run_op("mulh_mix", 2'd1, 32'h80000000, 32'h00000003, 5'd14, 32'hFFFFFFFE, 7, -1);
    run_op("stall", 2'd0, 32'd1000, 32'd1000, 5'd21, 32'd1000000, 10, 4);
    m7.stall = 1;
    repeat (2) begin
      @(negedge clk);
      check("hold_finish", m7.finish, 1'b1);
      check("hold_res", m7.res, 32'd1000000);
      check("hold_tag", m7.tag_out, 5'd21);
    end
    m7.stall = 0;
    @(negedge clk);
    check("hold_release", m7.finish, 1'b0);
    for (int k = 0; k < 40; k++) begin
      m7.EN = k < 10; m7.mode = 0; m7.A = k; m7.B = k + 1; m7.tag_in = k[4:0];
      @(negedge clk);
      busy_k[k] = m7.busy;
      if (m7.finish) begin
        fin_k.push_back(k);
        fin_t.push_back(m7.tag_out);
        fin_r.push_back(m7.res);
      end
    end
    check("b2b_count", fin_k.size(), 10);
    if (fin_k.size() == 10) begin
      check("b2b_first", fin_k[0], 6);
      for (int i = 0; i < 10; i++) begin
        check("b2b_cycle", fin_k[i], fin_k[0] + i);
        check("b2b_tag", fin_t[i], i);
        check("b2b_res", fin_r[i], i * (i + 1));
      end
      check("b2b_busy_last", busy_k[fin_k[9]], 1'b1);
      check("b2b_busy_fall", busy_k[fin_k[9] + 1], 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      m7.EN = 1; m7.mode = 0; m7.A = k + 2; m7.B = 3; m7.tag_in = 5'(k + 20);
      m7.flush = k == 3;
      @(negedge clk);
    end
    m7.EN = 0; m7.flush = 0;
    check("flush_busy", m7.busy, 1'b0);
    check("flush_finish", m7.finish, 1'b0);
    run_op("post_flush", 2'd0, 32'd5, 32'd5, 5'd9, 32'd25, 7, -1);
    sweep("sw_mulh", 2'd1, 16'h4000);
    sweep("sw_mul", 2'd0, 16'h0000);
    repeat (3) @(negedge clk);
    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
